// File: rtl/countdown_mmss.sv
// MM:SS countdown timer: loads a clamped minutes/seconds value, decrements it once
// per PRESCALE clocks while running, supports pause/resume and flags expiry at 00:00.
module countdown_mmss #(
  parameter int unsigned PRESCALE = 60,
  parameter int unsigned MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [5:0] PRE_TOP = 6'(PRESCALE);
  localparam logic [5:0] VAL_TOP = 6'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_q, state_nx;
  logic [5:0] min_q, min_nx;
  logic [5:0] sec_q, sec_nx;
  logic [5:0] pre_q, pre_nx;
  logic       armed_q, armed_nx;
  logic       done_q, done_nx;
  logic       advance;

  function automatic logic [5:0] clamp(input logic [5:0] v);
    return (v > VAL_TOP) ? VAL_TOP : v;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state_q;
    min_nx   = min_q;
    sec_nx   = sec_q;
    pre_nx   = pre_q;
    armed_nx = armed_q;
    done_nx  = 1'b0;
    advance  = 1'b0;

    if (load) begin
      min_nx   = clamp(min_in);
      sec_nx   = clamp(sec_in);
      pre_nx   = 6'd1;
      state_nx = IDLE;
      armed_nx = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A start after reset is ignored until a value has been loaded.
          if (start && !pause && armed_q) begin
            if ((min_q != 6'd0) || (sec_q != 6'd0)) begin
              state_nx = RUN;
              pre_nx   = 6'd1;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) state_nx = PAUSE;
          else       advance  = 1'b1;
        end
        PAUSE: begin
          // The resume edge counts as a running edge, so the held phase carries on.
          if (start && !pause) begin
            state_nx = RUN;
            advance  = 1'b1;
          end
        end
        DONE: ;
        default: state_nx = IDLE;
      endcase

      if (advance) begin
        if (pre_q == PRE_TOP) begin
          pre_nx = 6'd1;
          if (sec_q != 6'd0) begin
            sec_nx = sec_q - 6'd1;
          end else if (min_q != 6'd0) begin
            min_nx = min_q - 6'd1;
            sec_nx = VAL_TOP;
          end
          if ((min_nx == 6'd0) && (sec_nx == 6'd0)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end else begin
          pre_nx = pre_q + 6'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      pre_q   <= 6'd1;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      min_q   <= min_nx;
      sec_q   <= sec_nx;
      pre_q   <= pre_nx;
      armed_q <= armed_nx;
      done_q  <= done_nx;
    end
  end

  assign min_out = min_q;
  assign sec_out = sec_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == DONE);
  assign done    = done_q;

endmodule
